parking_gate_ctrl: RTL and testbench

Gate-side initiator for the parking occupancy counter. It debounces the entry and exit loop and beam sensors, decides whether to admit a car using the counter's vacancy flags, and drives both barriers. It emits the single-cycle `car_entered`/`car_exited` events, with their university-car qualifiers, that the occupancy counter consumes.

---
 rtl/parking_gate_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_ctrl
//  Description : Gate-side initiator for the parking occupancy counter.
//                Synchronizes and debounces the entry/exit loop and beam
//                sensors, decides admission from the counter's vacancy flags,
//                drives both barriers and emits the car_entered / car_exited
//                events (with university qualifiers) that the counter
//                consumes.
//  Ports       :
//     clk                  - single rising-edge clock
//     start                - synchronous active-low reset (0 = reset, 1 = run)
//     entry_loop/beam      - raw entry-gate loop and beam sensors
//     entry_uni_card       - raw university permit level at entry
//     exit_loop/beam       - raw exit-gate loop and beam sensors
//     exit_uni_card        - raw university permit level at exit
//     is_vacated_space     - general space available
//     uni_is_vacated_space - university space available
//     car_entered/exited   - one-cycle completion events (never coincident)
//     is_uni_car_entered/exited - qualifiers latched at each gate's decision
//     entry/exit_barrier_open   - barrier drive
//     entry_denied         - one-cycle pulse on refusal for lack of space
//     gate_timeout         - one-cycle pulse when either barrier aborts
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int OPEN_TIMEOUT    = 200,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic start,
   input  logic entry_loop,
   input  logic entry_beam,
   input  logic entry_uni_card,
   input  logic exit_loop,
   input  logic exit_beam,
   input  logic exit_uni_card,
   input  logic is_vacated_space,
   input  logic uni_is_vacated_space,
   output logic car_entered,
   output logic is_uni_car_entered,
   output logic car_exited,
   output logic is_uni_car_exited,
   output logic entry_barrier_open,
   output logic exit_barrier_open,
   output logic entry_denied,
   output logic gate_timeout
);

   localparam logic [CNT_W-1:0] c_DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(OPEN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DECIDE  = 3'd1,
      S_OPEN    = 3'd2,
      S_PASSING = 3'd3,
      S_CLEAR   = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Two-flop synchronizer for every raw input.
   // Bit order: 0 entry_loop, 1 entry_beam, 2 entry_card,
   //            3 exit_loop,  4 exit_beam,  5 exit_card
   // ------------------------------------------------------------------------
   logic [5:0] w_raw;
   logic [5:0] r_sync1;
   logic [5:0] r_sync2;

   assign w_raw = {exit_uni_card, exit_beam, exit_loop,
                   entry_uni_card, entry_beam, entry_loop};

   always_ff @(posedge clk) begin
      if (!start) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------------
   // Debouncers for the loop/beam channels.
   // Index: 0 entry_loop, 1 entry_beam, 2 exit_loop, 3 exit_beam.
   // The counter saturates at the limit; the level flips on the next
   // still-mismatched sample, so a change shows up 2 + DEBOUNCE_CYCLES edges
   // after the raw input is first sampled. w_rise is a same-edge strobe for
   // a debounced 0->1 transition.
   // ------------------------------------------------------------------------
   logic [3:0] w_deb_in;
   logic [3:0] w_deb;
   logic [3:0] w_rise;

   assign w_deb_in = {r_sync2[4], r_sync2[3], r_sync2[1], r_sync2[0]};

   for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic             r_level;
      logic [CNT_W-1:0] r_cnt;
      logic             w_mismatch;
      logic             w_flip;

      assign w_mismatch = w_deb_in[gi] ^ r_level;
      assign w_flip     = w_mismatch && (r_cnt == c_DEB_LIM);
      assign w_deb[gi]  = r_level;
      assign w_rise[gi] = w_flip && !r_level;

      always_ff @(posedge clk) begin
         if (!start) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
         end else if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Entry gate FSM
   // ------------------------------------------------------------------------
   state_t           r_ent_state;
   logic [CNT_W-1:0] r_ent_cnt;
   logic             w_ent_uni;
   logic             w_ent_admit;
   logic             w_ent_done;
   logic             w_ent_tmo;

   assign w_ent_uni   = r_sync2[2];
   assign w_ent_admit = w_ent_uni ? uni_is_vacated_space : is_vacated_space;
   // Completion is acted on the edge after the debounced beam fall.
   assign w_ent_done  = (r_ent_state == S_PASSING) && !w_deb[1];
   assign w_ent_tmo   = (r_ent_state == S_OPEN) && !w_rise[1] &&
                        (r_ent_cnt == c_TMO_LAST);

   always_ff @(posedge clk) begin
      if (!start) begin
         r_ent_state        <= S_IDLE;
         r_ent_cnt          <= '0;
         entry_barrier_open <= 1'b0;
         is_uni_car_entered <= 1'b0;
         entry_denied       <= 1'b0;
      end else begin
         entry_denied <= 1'b0;
         case (r_ent_state)
            S_IDLE: begin
               if (w_rise[0]) r_ent_state <= S_DECIDE;
            end
            S_DECIDE: begin
               if (w_ent_admit) begin
                  is_uni_car_entered <= w_ent_uni;
                  entry_barrier_open <= 1'b1;
                  r_ent_cnt          <= '0;
                  r_ent_state        <= S_OPEN;
               end else begin
                  entry_denied <= 1'b1;
                  r_ent_state  <= S_CLEAR;
               end
            end
            S_OPEN: begin
               if (w_rise[1]) begin
                  r_ent_state <= S_PASSING;
               end else if (w_ent_tmo) begin
                  entry_barrier_open <= 1'b0;
                  r_ent_state        <= S_CLEAR;
               end else begin
                  r_ent_cnt <= r_ent_cnt + CNT_W'(1);
               end
            end
            S_PASSING: begin
               if (w_ent_done) begin
                  entry_barrier_open <= 1'b0;
                  r_ent_state        <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (!w_deb[0]) r_ent_state <= S_IDLE;
            end
            default: r_ent_state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Exit gate FSM: same flow, but leaving is never refused.
   // ------------------------------------------------------------------------
   state_t           r_ex_state;
   logic [CNT_W-1:0] r_ex_cnt;
   logic             w_ex_uni;
   logic             w_ex_done;
   logic             w_ex_tmo;

   assign w_ex_uni  = r_sync2[5];
   assign w_ex_done = (r_ex_state == S_PASSING) && !w_deb[3];
   assign w_ex_tmo  = (r_ex_state == S_OPEN) && !w_rise[3] &&
                      (r_ex_cnt == c_TMO_LAST);

   always_ff @(posedge clk) begin
      if (!start) begin
         r_ex_state        <= S_IDLE;
         r_ex_cnt          <= '0;
         exit_barrier_open <= 1'b0;
         is_uni_car_exited <= 1'b0;
      end else begin
         case (r_ex_state)
            S_IDLE: begin
               if (w_rise[2]) r_ex_state <= S_DECIDE;
            end
            S_DECIDE: begin
               is_uni_car_exited <= w_ex_uni;
               exit_barrier_open <= 1'b1;
               r_ex_cnt          <= '0;
               r_ex_state        <= S_OPEN;
            end
            S_OPEN: begin
               if (w_rise[3]) begin
                  r_ex_state <= S_PASSING;
               end else if (w_ex_tmo) begin
                  exit_barrier_open <= 1'b0;
                  r_ex_state        <= S_CLEAR;
               end else begin
                  r_ex_cnt <= r_ex_cnt + CNT_W'(1);
               end
            end
            S_PASSING: begin
               if (w_ex_done) begin
                  exit_barrier_open <= 1'b0;
                  r_ex_state        <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (!w_deb[2]) r_ex_state <= S_IDLE;
            end
            default: r_ex_state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Event arbitration: an exit wins a collision; the entry event is parked
   // in a one-deep pending flag and released on the following cycle.
   // ------------------------------------------------------------------------
   logic r_pend;
   logic w_ent_due;

   assign w_ent_due = w_ent_done || r_pend;

   always_ff @(posedge clk) begin
      if (!start) begin
         car_entered  <= 1'b0;
         car_exited   <= 1'b0;
         r_pend       <= 1'b0;
         gate_timeout <= 1'b0;
      end else begin
         car_exited   <= w_ex_done;
         car_entered  <= w_ent_due && !w_ex_done;
         r_pend       <= w_ent_due && w_ex_done;
         gate_timeout <= w_ent_tmo || w_ex_tmo;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_gate_ctrl
//  Description : Directed bench for parking_gate_ctrl. Stimulus and expected
//                output waveforms are tables indexed by clock-edge number;
//                expectations are derived from the gate's timing rules
//                (debounce latency, decision edge, beam-fall event edge,
//                timeout edge, exit-first arbitration).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_ctrl;

   localparam int DEB  = 4;
   localparam int TMO  = 20;
   localparam int LAT  = 2 + DEB;   // raw sample edge -> debounced edge
   localparam int NEND = 440;
   localparam int MAXC = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic start, entry_loop, entry_beam, entry_uni_card;
   logic exit_loop, exit_beam, exit_uni_card;
   logic is_vacated_space, uni_is_vacated_space;
   logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
   logic entry_barrier_open, exit_barrier_open, entry_denied, gate_timeout;

   parking_gate_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .OPEN_TIMEOUT   (TMO),
      .CNT_W          (8)
   ) dut (
      .clk                 (clk),
      .start               (start),
      .entry_loop          (entry_loop),
      .entry_beam          (entry_beam),
      .entry_uni_card      (entry_uni_card),
      .exit_loop           (exit_loop),
      .exit_beam           (exit_beam),
      .exit_uni_card       (exit_uni_card),
      .is_vacated_space    (is_vacated_space),
      .uni_is_vacated_space(uni_is_vacated_space),
      .car_entered         (car_entered),
      .is_uni_car_entered  (is_uni_car_entered),
      .car_exited          (car_exited),
      .is_uni_car_exited   (is_uni_car_exited),
      .entry_barrier_open  (entry_barrier_open),
      .exit_barrier_open   (exit_barrier_open),
      .entry_denied        (entry_denied),
      .gate_timeout        (gate_timeout)
   );

   // Stimulus tables: value present at edge n. Gate index 0 = entry, 1 = exit.
   bit s_start[MAXC];
   bit s_loop [2][MAXC];
   bit s_beam [2][MAXC];
   bit s_card [2][MAXC];
   bit s_vac  [MAXC];
   bit s_uvac [MAXC];

   // Expected output after edge n.
   bit x_bar [2][MAXC];
   bit x_qual[2][MAXC];
   bit x_done[2][MAXC];   // completion before arbitration
   bit x_ev  [2][MAXC];   // car_entered / car_exited after arbitration
   bit x_den [MAXC];
   bit x_tmo [MAXC];

   int checks   = 0;
   int failures = 0;

   function automatic void stim(int kind, int g, int from, int to, bit v);
      for (int n = (from < 1) ? 1 : from; n < to && n < MAXC; n++) begin
         case (kind)
            0: s_start[n]   = v;
            1: s_loop[g][n] = v;
            2: s_beam[g][n] = v;
            3: s_card[g][n] = v;
            4: s_vac[n]     = v;
            5: s_uvac[n]    = v;
            default: ;
         endcase
      end
   endfunction

   // One car at gate g: loop first sampled at edge k, card level uni, beam
   // high over [b_on, b_off) (b_on = 0 means the beam never breaks).
   // Everything at or after abort_at is wiped by a reset.
   function automatic void txn(int g, int k, int loop_len, bit uni,
                               int b_on, int b_off, int abort_at);
      int t_dec;
      int t_close;
      bit admit;
      stim(1, g, k, k + loop_len, 1'b1);
      stim(3, g, k - 5, k + 10, uni);
      if (b_on > 0) stim(2, g, b_on, b_off, 1'b1);
      t_dec = k + LAT + 1;
      admit = (g == 1) ? 1'b1 : (uni ? s_uvac[t_dec] : s_vac[t_dec]);
      if (!admit) begin
         if (t_dec < abort_at) x_den[t_dec] = 1'b1;
         return;
      end
      t_close = (b_on > 0) ? (b_off + LAT + 1) : (t_dec + TMO);
      for (int n = t_dec; n < MAXC && n < abort_at; n++) x_qual[g][n] = uni;
      for (int n = t_dec; n < t_close && n < abort_at; n++) x_bar[g][n] = 1'b1;
      if (t_close < abort_at) begin
         if (b_on > 0) x_done[g][t_close] = 1'b1;
         else          x_tmo[t_close]     = 1'b1;
      end
   endfunction

   task automatic apply(int n);
      start                = s_start[n];
      entry_loop           = s_loop[0][n];
      entry_beam           = s_beam[0][n];
      entry_uni_card       = s_card[0][n];
      exit_loop            = s_loop[1][n];
      exit_beam            = s_beam[1][n];
      exit_uni_card        = s_card[1][n];
      is_vacated_space     = s_vac[n];
      uni_is_vacated_space = s_uvac[n];
   endtask

   task automatic chk(string nm, int n, logic act, bit exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d got=%b want=%b", nm, n, act, exp);
      end
   endtask

   task automatic compare(int n);
      chk("entry_barrier_open", n, entry_barrier_open, x_bar[0][n]);
      chk("exit_barrier_open",  n, exit_barrier_open,  x_bar[1][n]);
      chk("is_uni_car_entered", n, is_uni_car_entered, x_qual[0][n]);
      chk("is_uni_car_exited",  n, is_uni_car_exited,  x_qual[1][n]);
      chk("car_entered",        n, car_entered,        x_ev[0][n]);
      chk("car_exited",         n, car_exited,         x_ev[1][n]);
      chk("entry_denied",       n, entry_denied,       x_den[n]);
      chk("gate_timeout",       n, gate_timeout,       x_tmo[n]);
      // Hand-computed anchors for the table model.
      case (n)
         3:   chk("pin_reset_bar",      n, entry_barrier_open, 1'b0);
         10:  chk("pin_bar_not_yet",    n, entry_barrier_open, 1'b0);
         11:  chk("pin_bar_after_rel",  n, entry_barrier_open, 1'b1);
         13:  chk("pin_midop_reset",    n, exit_barrier_open,  1'b0);
         57:  chk("pin_entered_57",     n, car_entered,        1'b1);
         107: chk("pin_denied_107",     n, entry_denied,       1'b1);
         176: chk("pin_bar_before_tmo", n, entry_barrier_open, 1'b1);
         177: chk("pin_timeout_177",    n, gate_timeout,       1'b1);
         257: chk("pin_exited_257",     n, car_exited,         1'b1);
         258: chk("pin_entered_258",    n, car_entered,        1'b1);
         328: chk("pin_entered_328",    n, car_entered,        1'b1);
         387: chk("pin_denied_387",     n, entry_denied,       1'b1);
         default: ;
      endcase
   endtask

   initial begin
      // ---- scenario tables ----
      stim(0, 0, 1, MAXC, 1'b1);
      // Reset with all sensors high: start low for edges 1..3; the loop is
      // therefore first sampled at edge 4 and the barriers open at 4+7 = 11.
      // A second reset at edges 13..14 drops everything mid-operation.
      stim(0, 0, 1, 4, 1'b0);
      stim(0, 0, 13, 15, 1'b0);
      for (int g = 0; g < 2; g++) begin
         stim(2, g, 1, 13, 1'b1);
         stim(1, g, 1, 13, 1'b1);
         stim(3, g, 1, 13, 1'b1);
      end
      stim(4, 0, 1, 13, 1'b1);
      stim(5, 0, 1, 13, 1'b1);
      txn(0, 4, 9, 1'b1, 0, 0, 13);
      txn(1, 4, 9, 1'b1, 0, 0, 13);

      // General entry: beam high 10 cycles, falls at 50 -> event at 57.
      stim(4, 0, 25, 60, 1'b1);
      txn(0, 30, 40, 1'b0, 40, 50, MAXC);

      // University card with no university space -> refused at 107.
      stim(4, 0, 95, 135, 1'b1);
      txn(0, 100, 30, 1'b1, 0, 0, MAXC);

      // Timeout: university entry admitted, beam never breaks.
      stim(5, 0, 145, 180, 1'b1);
      txn(0, 150, 50, 1'b1, 0, 0, MAXC);

      // Simultaneous completion: both beams fall at 250.
      stim(4, 0, 225, 260, 1'b1);
      txn(0, 230, 50, 1'b0, 240, 250, MAXC);
      txn(1, 230, 50, 1'b1, 240, 250, MAXC);

      // Staggered: exit (non-uni) completes at 327, uni entry at 328.
      stim(5, 0, 295, 335, 1'b1);
      txn(0, 300, 40, 1'b1, 310, 321, MAXC);
      txn(1, 300, 40, 1'b0, 310, 320, MAXC);

      // 3-cycle loop glitch: nothing may happen.
      stim(1, 0, 360, 363, 1'b1);

      // Non-uni entry with only university space -> refused at 387.
      stim(5, 0, 375, 420, 1'b1);
      txn(0, 380, 30, 1'b0, 0, 0, MAXC);

      // Exit has priority; a colliding entry event slips one cycle.
      for (int n = 0; n < MAXC - 1; n++) begin
         x_ev[1][n] = x_done[1][n];
         if (x_done[0][n] && x_done[1][n]) x_ev[0][n + 1] = 1'b1;
         else if (x_done[0][n])            x_ev[0][n]     = 1'b1;
      end

      // ---- run ----
      apply(1);
      for (int n = 1; n <= NEND; n++) begin
         @(posedge clk);
         #1;
         apply(n + 1);
         @(negedge clk);
         compare(n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
